mc_alu_seq: RTL and testbench
=============================

Name: mc_alu_seq

Overview:
- Parametrised multi-cycle ALU for the multi-cycle CPU datapath.
- Adds registered result and flags, a start/done handshake, subtraction, XOR, iterative shifts and an iterative shift-add multiply.
- Driven by the control FSM: assert start, wait for done, then latch result and czn into the register file and flag register.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 4.
- SHW, $clog2(WIDTH), number of b bits used as the shift amount.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request operation; sampled only in IDLE
- op  in  3  opcode, sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- cin  in  1  carry-in for ADD, sampled with start
- result  out  WIDTH  registered result
- czn  out  3  registered flags {carry, zero, negative}
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse when result/czn update

Behaviour:
- Reset (async, rst_n=0): result=0, czn=3'b000, busy=0, done=0, state=IDLE, all iteration registers cleared. Reset asserted mid-operation aborts it; no done is produced.
- Opcodes:
  - 000 ADD: a+b+cin.
  - 001 AND.
  - 010 OR.
  - 011 SUB: a-b.
  - 100 XOR.
  - 101 SHL: logical left by b[SHW-1:0].
  - 110 SHR: logical right by b[SHW-1:0].
  - 111 MUL: low WIDTH bits of a*b.
- Flags:
  - z = (result==0).
  - n = result[WIDTH-1].
  - c for ADD = carry-out.
  - c for SUB = borrow (1 when a<b unsigned).
  - c for AND/OR/XOR = 0.
  - c for SHL/SHR = last bit shifted out; 0 when shift amount is 0.
  - c for MUL = 1 when any of the high WIDTH product bits is nonzero.
- States and transitions:
  - IDLE -> SINGLE: start with op in {ADD, AND, OR, SUB, XOR}.
  - IDLE -> SINGLE: start with SHL/SHR and shift amount 0.
  - IDLE -> ITER: start with SHL/SHR and shift amount > 0, or with MUL.
  - SINGLE -> IDLE: writes result and czn, pulses done.
  - ITER -> IDLE: writes result and czn and pulses done in the cycle the counter reaches 0.
- Latency, counted from the start edge to the cycle done is high:
  - Single-cycle ops: 1.
  - SHL/SHR: max(1, shamt), one bit per cycle.
  - MUL: WIDTH, one multiplier bit per cycle, accumulator 2*WIDTH wide.
- Handshake:
  - busy=1 in SINGLE and ITER.
  - start while busy=1 is ignored; there is no queueing.
  - start is accepted in the same cycle done is high, since the state is already IDLE after done.
  - Operands are captured at start; later changes to a, b or cin have no effect on the running operation.
- result and czn hold their value between done pulses; they never show partial iteration values.
- Unknown or X op: treated as ADD; this is the synthesis default branch.

Optional Feature:
- Macro: MC_ALU_MUL_EN.
- Defined: MUL implemented as described above.
- Undefined:
  - Multiplier accumulator and logic are not built.
  - op 111 completes as a single-cycle op with result=0 and czn=3'b010, latency 1.

Decomposition:
- Package mc_alu_pkg holds:
  - opcode constants OP_ADD..OP_MUL (3-bit);
  - state encoding IDLE/SINGLE/ITER;
  - flag bit indices FLAG_C=2, FLAG_Z=1, FLAG_N=0.
- One sub-module, mc_alu_iter, holds:
  - the iterative shift/multiply engine: counter, shift register, accumulator;
  - its ports: load, op select, operands in; finish pulse, value and carry out.
- The top level holds the FSM, the single-cycle datapath and the output registers.

Test Plan (WIDTH=8):
- ADD a=8'hFF, b=8'h01, cin=0 -> result=8'h00, czn=3'b110, done 1 cycle after start.
- SUB a=8'h05, b=8'h07 -> result=8'hFE, czn=3'b101. XOR a=8'hAA, b=8'hAA -> result=8'h00, czn=3'b010.
- SHL a=8'h81, b=3 -> result=8'h08, czn=3'b000, done 3 cycles after start. SHR a=8'h81, b=1 -> result=8'h40, czn=3'b100, latency 1. SHL with b=0 -> result=8'h81, czn=3'b001, latency 1.
- MUL a=8'h0C, b=8'h0A -> result=8'h78, czn=3'b000, done 8 cycles after start. MUL a=8'h10, b=8'h11 -> result=8'h10, czn=3'b100.
- start pulsed every cycle during a MUL -> only the first start is accepted, exactly one done, and result is unchanged until that done; back-to-back start in the done cycle is accepted.
- Reset: rst_n low at cycle 4 of a MUL -> outputs 0 immediately without waiting for a clock edge, no done. A fresh ADD after reset release completes normally.

Source files
------------

// File: rtl/mc_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu_pkg
// Purpose  : Shared opcodes, FSM state encoding and flag bit positions for
//            the multi-cycle ALU.
// Revision : 1.0 - initial release
// ============================================================================
package mc_alu_pkg;

  // 3-bit opcodes
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    ITER   = 2'd2
  } state_t;

  // Bit positions inside czn = {carry, zero, negative}
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // True for the two shift opcodes
  function automatic logic op_is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu_if
// Purpose  : Request/response bundle between the control FSM (master) and
//            the multi-cycle ALU (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mc_alu_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] result;
  logic [2:0]       czn;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, cin,
    input  result, czn, busy, done
  );

  modport slave (
    input  start, op, a, b, cin,
    output result, czn, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/mc_alu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu_iter
// Purpose  : Iterative engine: one-bit-per-cycle logical shifts and, when
//            MC_ALU_MUL_EN is defined, a shift-add multiplier with a
//            2*WIDTH accumulator. finish is high in the cycle whose clock
//            edge performs the final step; value/carry then show that
//            final step's outcome so the caller can register it directly.
// Config   : MC_ALU_MUL_EN - build the multiplier datapath
// Revision : 1.0 - initial release
// ============================================================================
module mc_alu_iter
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [2:0]       op,
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  output logic                  finish,
  output logic [WIDTH-1:0]      value,
  output logic                  carry
);

  // Counter must be able to hold WIDTH (multiply step count)
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    r_cnt;
  logic             r_left;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_sh_c;

  // One-bit shift step and the bit it pushes out
  always_comb begin
    w_sh_nxt = r_left ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
    w_sh_c   = r_left ? r_sh[WIDTH-1] : r_sh[0];
  end

  assign finish = (r_cnt == CW'(1));

`ifdef MC_ALU_MUL_EN
  logic               r_is_mul;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right
  always_comb begin
    w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                {1'b0, (r_acc[0] ? r_mcand : {WIDTH{1'b0}})};
    w_acc_nxt = {w_msum, r_acc[WIDTH-1:1]};
  end

  // Select the engine output according to the running operation
  always_comb begin
    value = r_is_mul ? w_acc_nxt[WIDTH-1:0]          : w_sh_nxt;
    carry = r_is_mul ? (|w_acc_nxt[2*WIDTH-1:WIDTH]) : w_sh_c;
  end

  // Multiplier state: load multiplier into the low half, step while counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_mul <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
    end else if (load) begin
      r_is_mul <= (op == OP_MUL);
      r_acc    <= {{WIDTH{1'b0}}, b};
      r_mcand  <= a;
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_nxt;
    end
  end

  // Step counter: WIDTH steps for multiply, shift amount for shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= (op == OP_MUL) ? CW'(WIDTH) : CW'(b[SHW-1:0]);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end
`else
  // Only the shift amount bits of b matter without a multiplier
  logic w_unused_b;
  assign w_unused_b = ^b[WIDTH-1:SHW];

  // Shift engine output
  always_comb begin
    value = w_sh_nxt;
    carry = w_sh_c;
  end

  // Step counter: one step per shift position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= CW'(b[SHW-1:0]);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end
`endif

  // Shift register and direction, loaded with operand A at start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_left <= 1'b0;
    end else if (load) begin
      r_sh   <= a;
      r_left <= (op == OP_SHL);
    end else if (r_cnt != '0) begin
      r_sh   <= w_sh_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mc_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu_seq
// Purpose  : Multi-cycle ALU with start/done handshake, registered result
//            and {carry, zero, negative} flags. Logic ops, add and subtract
//            finish in one cycle; shifts and multiply run in mc_alu_iter.
// Config   : MC_ALU_MUL_EN - iterative multiply; when undefined op 111
//            completes in one cycle with result 0.
// Revision : 1.0 - initial release
// ============================================================================
module mc_alu_seq
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  wire logic clk,
  input  wire logic rst_n,
  mc_alu_if.slave   bus
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_cin;

  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_czn;
  logic             r_done;

  logic [SHW-1:0]   w_shamt;
  logic             w_iter_op;
  logic             w_load_iter;
  logic             w_write;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_single_val;
  logic             w_single_c;

  logic             w_iter_finish;
  logic [WIDTH-1:0] w_iter_val;
  logic             w_iter_c;

  logic [WIDTH-1:0] w_wr_val;
  logic             w_wr_c;

  assign w_shamt = bus.b[SHW-1:0];

  // Decide whether the requested op needs the iterative engine
  always_comb begin
    w_iter_op = op_is_shift(bus.op) && (w_shamt != '0);
`ifdef MC_ALU_MUL_EN
    if (bus.op == OP_MUL) begin
      w_iter_op = 1'b1;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, engine load and result write strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load_iter = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = w_iter_op ? ITER : SINGLE;
          w_load_iter = w_iter_op;
        end
      end
      SINGLE: begin
        w_write     = 1'b1;
        w_state_nxt = IDLE;
      end
      ITER: begin
        if (w_iter_finish) begin
          w_write     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture operands at the accepted start so later bus changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= OP_ADD;
      r_cin <= 1'b0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_op  <= bus.op;
      r_cin <= bus.cin;
    end
  end

  // Single-cycle datapath on the captured operands; SUB carry is the borrow
  always_comb begin
    w_add        = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    w_sub        = {1'b0, r_a} - {1'b0, r_b};
    w_single_val = w_add[WIDTH-1:0];
    w_single_c   = w_add[WIDTH];
    case (r_op)
      OP_AND: begin w_single_val = r_a & r_b;      w_single_c = 1'b0;       end
      OP_OR:  begin w_single_val = r_a | r_b;      w_single_c = 1'b0;       end
      OP_SUB: begin w_single_val = w_sub[WIDTH-1:0]; w_single_c = w_sub[WIDTH]; end
      OP_XOR: begin w_single_val = r_a ^ r_b;      w_single_c = 1'b0;       end
      OP_SHL: begin w_single_val = r_a;            w_single_c = 1'b0;       end
      OP_SHR: begin w_single_val = r_a;            w_single_c = 1'b0;       end
      OP_MUL: begin w_single_val = '0;             w_single_c = 1'b0;       end
      default: begin
        w_single_val = w_add[WIDTH-1:0];
        w_single_c   = w_add[WIDTH];
      end
    endcase
  end

  mc_alu_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load_iter),
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .finish (w_iter_finish),
    .value  (w_iter_val),
    .carry  (w_iter_c)
  );

  // Pick the value being committed this cycle
  always_comb begin
    w_wr_val = (r_state == ITER) ? w_iter_val : w_single_val;
    w_wr_c   = (r_state == ITER) ? w_iter_c   : w_single_c;
  end

  // Output registers: only updated on completion, done pulses alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_czn    <= 3'b000;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_write;
      if (w_write) begin
        r_result       <= w_wr_val;
        r_czn[FLAG_C]  <= w_wr_c;
        r_czn[FLAG_Z]  <= (w_wr_val == '0);
        r_czn[FLAG_N]  <= w_wr_val[WIDTH-1];
      end
    end
  end

  assign bus.result = r_result;
  assign bus.czn    = r_czn;
  assign bus.done   = r_done;
  assign bus.busy   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mc_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_alu_seq
// Purpose  : Self-checking bench for mc_alu_seq (WIDTH=8): directed table,
//            randomized ops against an arithmetic reference model, plus
//            start-while-busy and asynchronous reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_alu_seq;
  import mc_alu_pkg::*;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mc_alu_if #(.WIDTH(W)) bus ();

  mc_alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [2:0]   czn;
    int           lat;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic [2:0]   czn;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the opcode definitions
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    exp_t   e;
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint mask = (longint'(1) << W) - 1;
    longint r    = 0;
    longint p;
    int     sh   = int'(ub % W);
    logic   c    = 1'b0;
    e.lat = 1;
    case (op)
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_SUB: begin r = (ua - ub) & mask; c = (ua < ub); end
      OP_SHL: begin
        r = (ua << sh) & mask;
        if (sh != 0) c = ((ua >> (W - sh)) & 1) != 0;
        if (sh > 1) e.lat = sh;
      end
      OP_SHR: begin
        r = ua >> sh;
        if (sh != 0) c = ((ua >> (sh - 1)) & 1) != 0;
        if (sh > 1) e.lat = sh;
      end
      OP_MUL: begin
`ifdef MC_ALU_MUL_EN
        p = ua * ub;
        r = p & mask;
        c = (p >> W) != 0;
        e.lat = W;
`else
        p = 0;
        r = p;
`endif
      end
      default: begin
        p = ua + ub + longint'(cin);
        r = p & mask;
        c = ((p >> W) & 1) != 0;
      end
    endcase
    e.res = r[W-1:0];
    e.czn = {c, (r == 0), r[W-1]};
    return e;
  endfunction

  // Issue one op, scramble the bus after the start edge, measure latency
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
    lat = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic check_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin, input logic [W-1:0] eres,
                          input logic [2:0] eczn, input int elat);
    int lat;
    run_op(op, a, b, cin, lat);
    check({tag, "_lat"},    lat,        elat);
    check({tag, "_result"}, bus.result, eres);
    check({tag, "_czn"},    bus.czn,    eczn);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic [W-1:0] res, input logic [2:0] czn,
                              input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cin = cin; v.res = res; v.czn = czn; v.lat = lat;
    return v;
  endfunction

  initial begin
    vec_t         tbl[$];
    exp_t         e;
    int           lat;
    logic [2:0]   lop;
    logic [W-1:0] la, lb, lres;
    logic [2:0]   lczn;
    int           llat;
    logic         seen;

    bus.start = 1'b0;
    bus.op    = OP_ADD;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", bus.result, 8'h00);
    check("rst_czn",    bus.czn,    3'b000);
    check("rst_busy",   bus.busy,   1'b0);
    check("rst_done",   bus.done,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    tbl.push_back(mk(OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 3'b110, 1));
    tbl.push_back(mk(OP_ADD, 8'h7F, 8'h00, 1'b1, 8'h80, 3'b001, 1));
    tbl.push_back(mk(OP_SUB, 8'h05, 8'h07, 1'b0, 8'hFE, 3'b101, 1));
    tbl.push_back(mk(OP_SUB, 8'h07, 8'h05, 1'b1, 8'h02, 3'b000, 1));
    tbl.push_back(mk(OP_XOR, 8'hAA, 8'hAA, 1'b0, 8'h00, 3'b010, 1));
    tbl.push_back(mk(OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 3'b000, 1));
    tbl.push_back(mk(OP_OR,  8'h80, 8'h01, 1'b1, 8'h81, 3'b001, 1));
    tbl.push_back(mk(OP_SHL, 8'h81, 8'h03, 1'b0, 8'h08, 3'b000, 3));
    tbl.push_back(mk(OP_SHR, 8'h81, 8'h01, 1'b0, 8'h40, 3'b100, 1));
    tbl.push_back(mk(OP_SHL, 8'h81, 8'h00, 1'b0, 8'h81, 3'b001, 1));
    tbl.push_back(mk(OP_SHR, 8'h80, 8'hFF, 1'b0, 8'h01, 3'b000, 7));
    tbl.push_back(mk(OP_SHL, 8'h81, 8'hF2, 1'b0, 8'h04, 3'b000, 2));
`ifdef MC_ALU_MUL_EN
    tbl.push_back(mk(OP_MUL, 8'h0C, 8'h0A, 1'b0, 8'h78, 3'b000, 8));
    tbl.push_back(mk(OP_MUL, 8'h10, 8'h11, 1'b0, 8'h10, 3'b100, 8));
`else
    tbl.push_back(mk(OP_MUL, 8'h0C, 8'h0A, 1'b0, 8'h00, 3'b010, 1));
    tbl.push_back(mk(OP_MUL, 8'h10, 8'h11, 1'b0, 8'h00, 3'b010, 1));
`endif
    foreach (tbl[i]) begin
      check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin,
               tbl[i].res, tbl[i].czn, tbl[i].lat);
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      lop = 3'($urandom_range(0, 7));
      la  = W'($urandom);
      lb  = W'($urandom);
      e   = model(lop, la, lb, i[0]);
      check_op($sformatf("rnd%0d_op%0d", i, lop), lop, la, lb, i[0], e.res, e.czn, e.lat);
    end

    // Long op used by the busy and reset sequences
`ifdef MC_ALU_MUL_EN
    lop = OP_MUL; la = 8'h0C; lb = 8'h0A; lres = 8'h78; lczn = 3'b000; llat = 8;
`else
    lop = OP_SHL; la = 8'h81; lb = 8'h07; lres = 8'h80; lczn = 3'b001; llat = 7;
`endif

    // start held high during a long op: only the first is taken, one done,
    // result held, then the start seen in the done cycle is accepted
    check_op("pre_spam", OP_ADD, 8'h12, 8'h22, 1'b0, 8'h34, 3'b000, 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = lop;
    bus.a     = la;
    bus.b     = lb;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.op  = OP_ADD;
    bus.a   = 8'h01;
    bus.b   = 8'h02;
    bus.cin = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = cyc;
        break;
      end
      check("spam_hold_result", bus.result, 8'h34);
      check("spam_busy", bus.busy, 1'b1);
    end
    check("spam_lat",    lat,        llat);
    check("spam_result", bus.result, lres);
    check("spam_czn",    bus.czn,    lczn);
    @(posedge clk);
    #1;
    check("spam_done_pulse", bus.done, 1'b0);
    check("b2b_accept_busy", bus.busy, 1'b1);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_done",   bus.done,   1'b1);
    check("b2b_result", bus.result, 8'h03);
    check("b2b_czn",    bus.czn,    3'b000);
    @(posedge clk);
    #1;
    check("b2b_idle_busy", bus.busy, 1'b0);
    check("b2b_idle_done", bus.done, 1'b0);

    // Asynchronous reset in the middle of a long op
    check_op("pre_rst", OP_ADD, 8'h40, 8'h40, 1'b0, 8'h80, 3'b001, 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = lop;
    bus.a     = la;
    bus.b     = lb;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", bus.result, 8'h00);
    check("arst_czn",    bus.czn,    3'b000);
    check("arst_busy",   bus.busy,   1'b0);
    check("arst_done",   bus.done,   1'b0);
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      seen = seen | bus.done;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen = seen | bus.done | bus.busy;
    end
    check("arst_no_done", seen, 1'b0);
    check_op("post_rst", OP_ADD, 8'h05, 8'h03, 1'b1, 8'h09, 3'b000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
